adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Receive-side counterpart of dac_driver.
- On trigger_in it waits a programmable pre-delay, then captures a programmable number of 256-bit ADC AXIS words into an internal buffer.
- It then drains the buffer to a DMA-facing AXIS master, with tlast on the final word.
- Configuration loads over the same gpio_ctrl/select_in serial shift interface as dac_driver, using the rfsoc_config bit indices.

Parameters:
- SAMPLES_PER_WORD, 16, number of 16-bit samples per AXIS word; data width is 16*SAMPLES_PER_WORD.
- DEPTH, 64, capture buffer depth in words; must be a power of two.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- rst  in  1  reset, asynchronous and active-low; one clock.
- gpio_ctrl  in  16  serial config bus; uses the rfsoc_config indices sdata, cycle_count_clk and pre_delay_cycle_clk.
- select_in  in  1  enables serial loading when high.
- s_axis_tdata  in  256  ADC sample word.
- s_axis_tvalid  in  1  ADC word valid.
- s_axis_tready  out  1  always 1 when out of reset; the ADC cannot be stalled.
- m_axis_tdata  out  256  captured word to DMA.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  DMA ready.
- m_axis_tlast  out  1  high on the final drained word.
- trigger_in  in  1  capture start request, level-sampled.
- busy  out  1  high in any state other than IDLE.
- missed_trigger  out  1  sticky; set when a trigger arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all shift registers, counters and pointers cleared.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, missed_trigger=0, s_axis_tready=0.
  - s_axis_tready=1 from the first clk edge after rst deasserts.
  - Reset mid-capture or mid-drain abandons the operation; no partial tlast is emitted.
- Serial load:
  - gpio_ctrl is registered twice in clk; rising edges are detected on cycle_count_clk and pre_delay_cycle_clk.
  - On a rising edge with select_in=1, the matching 256-bit register shifts right and sdata enters bit 255.
  - The host sends 256 bits LSB-first, so after 256 edges the register holds the value exactly.
  - Edges with select_in=0 are ignored.
  - Only bits [15:0] are used: capture_len=cycle_count[15:0], pre_delay=pre_delay[15:0].
  - Both values are latched into active copies when a trigger is accepted. Shifting during an active capture has no effect on that capture.
- Effective length: eff_len = min(capture_len, DEPTH).
  - capture_len=0 means triggers are accepted as no-ops: no state change, missed_trigger is not set.
- FSM states: IDLE, PRE_DELAY, CAPTURE, DRAIN.
  - IDLE: trigger_in=1 sampled at edge T with eff_len>0 gives PRE_DELAY at T+1 if pre_delay>0, otherwise CAPTURE at T+1. Write pointer and beat counter reset to 0.
  - PRE_DELAY: counts clk cycles (not beats). After exactly pre_delay cycles it enters CAPTURE, so the first capture cycle is T+1+pre_delay.
  - CAPTURE:
    - Each cycle with s_axis_tvalid=1 writes s_axis_tdata to buf[wr_ptr] and increments wr_ptr and the beat count.
    - Cycles with tvalid=0 write nothing and do not count.
    - On the write of beat eff_len, the next state is DRAIN.
  - DRAIN:
    - Words buf[0..eff_len-1] are presented in order. The first word is valid no later than 2 cycles after entering DRAIN.
    - AXIS rules: tdata and tlast are stable while tvalid=1 and tready=0; a word advances only on tvalid&&tready.
    - tvalid is never dropped before a handshake.
    - m_axis_tlast=1 only with word eff_len-1; eff_len=1 gives a single word with tlast=1.
    - After the tlast handshake, tvalid=0 and state=IDLE on the next edge; back-to-back triggers are accepted from then on.
- trigger_in high while busy sets missed_trigger. It clears only on reset.
- A trigger held high over several cycles starts one capture. Further high cycles while busy set missed_trigger.
- Pointers are log2(DEPTH) bits. The beat counter is 16 bits, with comparisons against eff_len; there is no wrap within a capture.
- Buffer:
  - Single-port write/read is sufficient, because CAPTURE and DRAIN never overlap.
  - The read path may use registered RAM output plus a one-entry holding register to meet tready backpressure.

Test Plan:
- Load capture_len=1, pre_delay=1; ADC streams words {16{16'h0001}}, 0002, ... with tvalid=1 every cycle; trigger at edge T. Required: the word present at T+2 is captured; one m_axis word with tlast=1; then busy=0.
- capture_len=5, pre_delay=2; ADC words AAAA, BBBB, CCCC, DDDD, EEEE replicated, tvalid toggling 1010. Required: exactly those 5 words drained in order; tlast only on EEEE; pre-delay counts cycles, not beats.
- capture_len=4; m_axis_tready pattern 0,0,1,0,1,1,0,1. Required: tdata/tlast held stable while stalled; 4 handshakes; tlast on the 4th handshake.
- capture_len=200 with DEPTH=64. Required: 64 words drained, tlast on word 63. A trigger pulsed during DRAIN sets missed_trigger=1 and starts no capture.
- Shift pre_delay=7 with select_in=0. Required: the register is unchanged. Reload with select_in=1 mid-capture. Required: the current capture is unaffected and the next capture uses 7.
- Assert rst=0 for 3 cycles during CAPTURE. Required: immediately m_axis_tvalid=0, busy=0, missed_trigger=0. After release, s_axis_tready=1 next edge; triggers are no-ops until capture_len is reloaded, since config was cleared.

Source files
------------

// File: rtl/adc_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_if
// Brief    : AXI4-Stream style bundle used for the ADC input and DMA output.
// Revision : 1.0
// ============================================================================
interface adc_capture_if #(
    parameter int DATA_W = 256
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Brief    : Triggered ADC burst capture into a buffer, drained to an AXIS master.
// Revision : 1.0
// ============================================================================
module adc_capture #(
    parameter int SAMPLES_PER_WORD    = 16,
    parameter int DEPTH               = 64,
    parameter int SDATA_BIT           = 0,
    parameter int CYCLE_COUNT_CLK_BIT = 1,
    parameter int PRE_DELAY_CLK_BIT   = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [15:0] gpio_ctrl,
    input  wire logic        select_in,
    adc_capture_if.slave     s_axis,
    adc_capture_if.master    m_axis,
    input  wire logic        trigger_in,
    output logic             busy,
    output logic             missed_trigger
);

    localparam int              c_dw        = 16 * SAMPLES_PER_WORD;
    localparam int              c_aw        = $clog2(DEPTH);
    localparam logic [15:0]     c_depth_len = 16'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRE_DELAY = 2'd1,
        S_CAPTURE   = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Configuration bus synchroniser: {pre_delay_clk, cycle_count_clk, sdata}
    logic [2:0]   r_cfg_s1;
    logic [2:0]   r_cfg_s2;
    logic [1:0]   r_cfg_s3;
    logic         r_sel_s1;
    logic         r_sel_s2;
    logic [255:0] r_cycle_sh;
    logic [255:0] r_pre_sh;

    logic         w_cyc_rise;
    logic         w_pre_rise;
    logic [15:0]  w_cap_len;
    logic [15:0]  w_pre_len;
    logic [15:0]  w_eff_len;

    logic [15:0]     r_len;
    logic [15:0]     r_pd;
    logic [15:0]     r_pd_cnt;
    logic [15:0]     r_beat;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [15:0]     r_rd_left;

    logic [c_dw-1:0] r_mem [DEPTH];
    logic [c_dw-1:0] r_out_data;
    logic            r_out_vld;
    logic            r_out_last;
    logic            r_s_ready;
    logic            r_missed;

    logic w_accept;
    logic w_pd_done;
    logic w_wr_en;
    logic w_last_beat;
    logic w_fetch;
    logic w_hs;
    logic w_done;
    logic w_unused;

    assign w_unused = ^{gpio_ctrl, s_axis.tlast};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_s1   <= '0;
            r_cfg_s2   <= '0;
            r_cfg_s3   <= '0;
            r_sel_s1   <= 1'b0;
            r_sel_s2   <= 1'b0;
            r_cycle_sh <= '0;
            r_pre_sh   <= '0;
        end else begin
            r_cfg_s1 <= {gpio_ctrl[PRE_DELAY_CLK_BIT], gpio_ctrl[CYCLE_COUNT_CLK_BIT],
                         gpio_ctrl[SDATA_BIT]};
            r_cfg_s2 <= r_cfg_s1;
            r_cfg_s3 <= r_cfg_s2[2:1];
            r_sel_s1 <= select_in;
            r_sel_s2 <= r_sel_s1;
            if (w_cyc_rise && r_sel_s2) begin
                r_cycle_sh <= {r_cfg_s2[0], r_cycle_sh[255:1]};
            end
            if (w_pre_rise && r_sel_s2) begin
                r_pre_sh <= {r_cfg_s2[0], r_pre_sh[255:1]};
            end
        end
    end

    assign w_cyc_rise = r_cfg_s2[1] & ~r_cfg_s3[0];
    assign w_pre_rise = r_cfg_s2[2] & ~r_cfg_s3[1];
    assign w_cap_len  = r_cycle_sh[15:0];
    assign w_pre_len  = r_pre_sh[15:0];
    assign w_eff_len  = (w_cap_len > c_depth_len) ? c_depth_len : w_cap_len;

    // A zero-length configuration turns triggers into no-ops rather than misses.
    assign w_accept    = (r_state == S_IDLE) && trigger_in && (w_eff_len != 16'd0);
    assign w_pd_done   = (r_pd_cnt == (r_pd - 16'd1));
    assign w_wr_en     = (r_state == S_CAPTURE) && s_axis.tvalid && r_s_ready;
    assign w_last_beat = w_wr_en && (r_beat == (r_len - 16'd1));
    assign w_hs        = r_out_vld && m_axis.tready;
    assign w_done      = w_hs && r_out_last;
    assign w_fetch     = (r_state == S_DRAIN) && (r_rd_left != 16'd0) &&
                         (!r_out_vld || m_axis.tready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = (w_pre_len != 16'd0) ? S_PRE_DELAY : S_CAPTURE;
                end
            end
            S_PRE_DELAY: begin
                if (w_pd_done) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_last_beat) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Active copies of the configuration are frozen at trigger acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len     <= '0;
            r_pd      <= '0;
            r_pd_cnt  <= '0;
            r_beat    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_left <= '0;
        end else begin
            if (w_accept) begin
                r_len     <= w_eff_len;
                r_pd      <= w_pre_len;
                r_pd_cnt  <= '0;
                r_beat    <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_left <= w_eff_len;
            end
            if (r_state == S_PRE_DELAY) begin
                r_pd_cnt <= r_pd_cnt + 16'd1;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_beat   <= r_beat + 16'd1;
            end
            if (w_fetch) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_rd_left <= r_rd_left - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= s_axis.tdata;
        end
    end

    // The output register doubles as the registered RAM read port; it only
    // reloads when empty or being consumed, so backpressure holds the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_out_data <= r_mem[r_rd_ptr];
                r_out_vld  <= 1'b1;
                r_out_last <= (r_rd_left == 16'd1);
            end else if (w_hs) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_ready <= 1'b0;
            r_missed  <= 1'b0;
        end else begin
            r_s_ready <= 1'b1;
            if (trigger_in && (r_state != S_IDLE)) begin
                r_missed <= 1'b1;
            end
        end
    end

    assign s_axis.tready  = r_s_ready;
    assign m_axis.tdata   = r_out_data;
    assign m_axis.tvalid  = r_out_vld;
    assign m_axis.tlast   = r_out_last;
    assign missed_trigger = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture
// Brief    : Directed captures of adc_capture checked through an AXIS scoreboard.
// Revision : 1.0
// ============================================================================
module tb_adc_capture;

    localparam int SDATA_BIT = 0;
    localparam int CYC_BIT   = 1;
    localparam int PRE_BIT   = 2;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic [15:0] gpio_ctrl  = 16'h0000;
    logic        select_in  = 1'b0;
    logic        trigger_in = 1'b0;
    logic        busy;
    logic        missed_trigger;

    adc_capture_if #(.DATA_W(256)) s_if ();
    adc_capture_if #(.DATA_W(256)) m_if ();

    adc_capture #(
        .SAMPLES_PER_WORD    (16),
        .DEPTH               (64),
        .SDATA_BIT           (SDATA_BIT),
        .CYCLE_COUNT_CLK_BIT (CYC_BIT),
        .PRE_DELAY_CLK_BIT   (PRE_BIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_ctrl      (gpio_ctrl),
        .select_in      (select_in),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .trigger_in     (trigger_in),
        .busy           (busy),
        .missed_trigger (missed_trigger)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic         l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic         rdy_mode = 1'b0;
    logic [7:0]   rdy_pat  = 8'b1011_0100;  // bit i is the tready for stall step i
    int           rdy_idx  = 0;

    logic         mon_pv = 1'b0;
    logic         mon_pr = 1'b0;
    logic         mon_pl = 1'b0;
    logic [255:0] mon_pd = '0;

    logic [15:0]  t2_s [12] = '{16'h1111, 16'h1111, 16'h1111, 16'hAAAA, 16'h5555, 16'hBBBB,
                                16'h5555, 16'hCCCC, 16'h5555, 16'hDDDD, 16'h5555, 16'hEEEE};
    logic         t2_v [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] s, input logic l);
        exp_t e;
        e.d = {16{s}};
        e.l = l;
        q.push_back(e);
    endtask

    task automatic load(input int clk_bit, input logic [15:0] val, input logic sel);
        logic [255:0] v;
        v = {240'd0, val};
        select_in = sel;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            gpio_ctrl[SDATA_BIT] = v[i];
            gpio_ctrl[clk_bit]   = 1'b1;
            @(negedge clk);
            gpio_ctrl[clk_bit]   = 1'b0;
        end
        repeat (4) @(negedge clk);
        select_in = 1'b0;
    endtask

    // Word driven at step k carries sample k+1 in every lane.
    task automatic stream(input int n, input int t0, input int t1, input logic v);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            trigger_in  = (k == t0) || (k == t1);
            s_if.tdata  = {16{16'(k + 1)}};
            s_if.tvalid = v;
        end
        @(negedge clk);
        trigger_in  = 1'b0;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < 400)) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk({nm, "_idle"}, busy, 1'b0);
    endtask

    initial begin : tready_driver
        m_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode) begin
                m_if.tready = rdy_pat[rdy_idx];
                if (m_if.tvalid) rdy_idx = (rdy_idx + 1) % 8;
            end else begin
                m_if.tready = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                if (mon_pv && !mon_pr) begin
                    chk("hold_valid", m_if.tvalid, 1'b1);
                    chk("hold_data", m_if.tdata, mon_pd);
                    chk("hold_last", m_if.tlast, mon_pl);
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h, expected no word", m_if.tdata);
                    end else begin
                        e = q.pop_front();
                        chk("word_data", m_if.tdata, e.d);
                        chk("word_last", m_if.tlast, e.l);
                    end
                end
            end
            mon_pv = m_if.tvalid;
            mon_pr = m_if.tready;
            mon_pd = m_if.tdata;
            mon_pl = m_if.tlast;
        end
    end

    initial begin : stimulus
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        chk("rst_m_tvalid", m_if.tvalid, 1'b0);
        chk("rst_m_tlast", m_if.tlast, 1'b0);
        chk("rst_m_tdata", m_if.tdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_missed", missed_trigger, 1'b0);
        chk("rst_s_tready", s_if.tready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #4;
        chk("s_tready_up", s_if.tready, 1'b1);

        // Single word, pre-delay 1: sample at T+2 is captured
        load(CYC_BIT, 16'd1, 1'b1);
        load(PRE_BIT, 16'd1, 1'b1);
        push_exp(16'd3, 1'b1);
        stream(8, 0, -1, 1'b1);
        wait_idle("t1");

        // Five words, tvalid toggling, pre-delay counted in cycles
        load(CYC_BIT, 16'd5, 1'b1);
        load(PRE_BIT, 16'd2, 1'b1);
        push_exp(16'hAAAA, 1'b0);
        push_exp(16'hBBBB, 1'b0);
        push_exp(16'hCCCC, 1'b0);
        push_exp(16'hDDDD, 1'b0);
        push_exp(16'hEEEE, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            trigger_in  = (k == 0);
            s_if.tdata  = {16{t2_s[k]}};
            s_if.tvalid = t2_v[k];
            if (k == 1) begin
                #4;
                chk("t2_busy", busy, 1'b1);
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        wait_idle("t2");

        // Four words under DMA backpressure
        load(CYC_BIT, 16'd4, 1'b1);
        load(PRE_BIT, 16'd0, 1'b1);
        rdy_idx  = 0;
        rdy_mode = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(16'(i + 2), i == 3);
        stream(10, 0, -1, 1'b1);
        wait_idle("t3");
        rdy_mode = 1'b0;
        chk("t3_missed", missed_trigger, 1'b0);

        // Length clamped to DEPTH, trigger during drain is missed
        load(CYC_BIT, 16'd200, 1'b1);
        for (int i = 0; i < 64; i++) push_exp(16'(i + 2), i == 63);
        stream(90, 0, 80, 1'b1);
        wait_idle("t4");
        chk("t4_missed", missed_trigger, 1'b1);
        repeat (3) @(negedge clk);
        #4;
        chk("t4_no_restart", busy, 1'b0);

        // Unselected shift is ignored; reload mid-capture does not disturb it
        load(PRE_BIT, 16'd7, 1'b0);
        load(CYC_BIT, 16'd2, 1'b1);
        push_exp(16'h0E01, 1'b0);
        push_exp(16'h0E02, 1'b1);
        @(negedge clk);
        trigger_in  = 1'b1;
        s_if.tdata  = {16{16'h0E00}};
        s_if.tvalid = 1'b1;
        @(negedge clk);
        trigger_in  = 1'b0;
        s_if.tdata  = {16{16'h0E01}};
        @(negedge clk);
        s_if.tvalid = 1'b0;
        load(PRE_BIT, 16'd7, 1'b1);
        #4;
        chk("t5_busy_mid", busy, 1'b1);
        @(negedge clk);
        s_if.tdata  = {16{16'h0E02}};
        s_if.tvalid = 1'b1;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        wait_idle("t5a");
        push_exp(16'd9, 1'b0);
        push_exp(16'd10, 1'b1);
        stream(14, 0, -1, 1'b1);
        wait_idle("t5b");

        // Reset during capture
        @(negedge clk);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #4;
        chk("t6_m_tvalid", m_if.tvalid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_missed", missed_trigger, 1'b0);
        chk("t6_s_tready_rst", s_if.tready, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #4;
        chk("t6_s_tready_up", s_if.tready, 1'b1);
        stream(6, 0, -1, 1'b1);
        #4;
        chk("t6_noop_busy", busy, 1'b0);
        chk("t6_noop_missed", missed_trigger, 1'b0);
        load(CYC_BIT, 16'd1, 1'b1);
        push_exp(16'd2, 1'b1);
        stream(6, 0, -1, 1'b1);
        wait_idle("t6");

        repeat (5) @(negedge clk);
        #4;
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
